histogram_reader: RTL and testbench

- Read-side companion to the count-unique-values datapath.
- The writer side builds per-value saturating counts in an inferred BRAM. This block scans that BRAM from bin 0 to NUM_BINS-1.
- Each (bin, count) pair goes out on a valid/ready stream.
- On completion it reports how many bins held a nonzero count (the unique-value total).
- It owns the BRAM read port only and never writes the memory.

---
 rtl/histogram_reader_if.sv | 24 ++
 rtl/histogram_reader.sv | 109 ++++++++++
 tb/tb_histogram_reader.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/histogram_reader_if.sv
// BRAM read port and (bin, count) output stream of histogram_reader.
// master = reader side, slave = memory/downstream side.
interface histogram_reader_if #(
    parameter int ADDR_W  = 8,
    parameter int COUNT_W = 6
);
    logic               rd_en_out;
    logic [ADDR_W-1:0]  rd_addr_out;
    logic [COUNT_W-1:0] rd_data_in;
    logic               valid_out;
    logic               ready_in;
    logic [ADDR_W-1:0]  bin_out;
    logic [COUNT_W-1:0] count_out;

    modport master (
        output rd_en_out, rd_addr_out, valid_out, bin_out, count_out,
        input  rd_data_in, ready_in
    );

    modport slave (
        input  rd_en_out, rd_addr_out, valid_out, bin_out, count_out,
        output rd_data_in, ready_in
    );
endinterface

// File: rtl/histogram_reader.sv
// Scans a count BRAM from bin 0 to NUM_BINS-1, streams (bin, count) pairs and
// totals nonzero bins. Define HISTOGRAM_READER_SKIP_ZERO_EN to drop zero bins from the stream.
module histogram_reader #(
    parameter  int NUM_BINS  = 256,
    parameter  int COUNT_MAX = 32,
    localparam int ADDR_W    = $clog2(NUM_BINS),
    localparam int COUNT_W   = $clog2(COUNT_MAX) + 1,
    localparam int UNIQ_W    = $clog2(NUM_BINS) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [UNIQ_W-1:0] unique_count_out,
    histogram_reader_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [COUNT_W-1:0] CMAX     = COUNT_W'(COUNT_MAX);
    localparam logic [ADDR_W-1:0]  LAST_BIN = ADDR_W'(NUM_BINS - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  bin_q, bin_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [UNIQ_W-1:0]  uniq_q, uniq_d;
    logic [COUNT_W-1:0] clamped;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            count_q <= '0;
            uniq_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            count_q <= count_d;
            uniq_q  <= uniq_d;
        end
    end

    assign clamped = (bus.rd_data_in > CMAX) ? CMAX : bus.rd_data_in;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        count_d = count_q;
        uniq_d  = uniq_q;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    bin_d   = '0;
                    uniq_d  = '0;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                count_d = clamped;
                if (clamped != '0) begin
                    uniq_d = uniq_q + UNIQ_W'(1);
                end
                state_d = S_PRESENT;
`ifdef HISTOGRAM_READER_SKIP_ZERO_EN
                // Zero bins advance straight to the next read (or finish) without a beat.
                if (clamped == '0) begin
                    if (bin_q == LAST_BIN) begin
                        state_d = S_DONE;
                    end else begin
                        bin_d   = bin_q + ADDR_W'(1);
                        state_d = S_READ;
                    end
                end
`endif
            end
            S_PRESENT: begin
                if (bus.ready_in) begin
                    if (bin_q == LAST_BIN) begin
                        state_d = S_DONE;
                    end else begin
                        bin_d   = bin_q + ADDR_W'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // rd_addr_out tracks the bin register so it holds its value outside READ.
    assign bus.rd_en_out    = (state_q == S_READ);
    assign bus.rd_addr_out  = bin_q;
    assign bus.valid_out    = (state_q == S_PRESENT);
    assign bus.bin_out      = bin_q;
    assign bus.count_out    = count_q;
    assign busy_out         = (state_q != S_IDLE);
    assign done_out         = (state_q == S_DONE);
    assign unique_count_out = uniq_q;

endmodule

// File: tb/tb_histogram_reader.sv
// Self-checking bench for histogram_reader (NUM_BINS=8, COUNT_MAX=32) against a
// per-bin reference model; honours HISTOGRAM_READER_SKIP_ZERO_EN.
module tb_histogram_reader;
    localparam int NB = 8;
    localparam int CM = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_in = 1'b0;
    logic       busy_out;
    logic       done_out;
    logic [3:0] unique_count_out;

    int checks = 0;
    int errors = 0;

    logic [5:0] mem [NB];

    int got_beat[$];
    int exp_beat[$];
    int exp_uniq, exp_first, exp_done;
    int first_valid, done_cyc, done_cnt, busy_fall, hold_viol, stall_seen;

    always #5 clk = ~clk;

    histogram_reader_if #(.ADDR_W(3), .COUNT_W(6)) bus ();

    histogram_reader #(.NUM_BINS(NB), .COUNT_MAX(CM)) dut (
        .clk              (clk),
        .reset            (reset),
        .start_in         (start_in),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .unique_count_out (unique_count_out),
        .bus              (bus)
    );

    // Behavioural BRAM: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en_out) bus.rd_data_in <= mem[bus.rd_addr_out];
    end

    // Expected beats, unique total and timing (ready held high) from the memory contents.
    function automatic void build_model();
        int t;
        int c;
        bit present;
        exp_beat.delete();
        exp_uniq  = 0;
        exp_first = -1;
        t = 1;
        for (int b = 0; b < NB; b++) begin
            c = (int'(mem[b]) > CM) ? CM : int'(mem[b]);
            if (c != 0) exp_uniq++;
            present = 1'b1;
`ifdef HISTOGRAM_READER_SKIP_ZERO_EN
            present = (c != 0);
`endif
            if (present) begin
                exp_beat.push_back(b * 256 + c);
                if (exp_first < 0) exp_first = t + 2;
                t += 3;
            end else begin
                t += 2;
            end
        end
        exp_done = t;
    endfunction

    task automatic run_scan(input int stall_bin, input int stall_len, input bit rand_rdy,
                            input bit poke, input int abort_bin, output bit aborted);
        int t;
        int stall_left;
        bit holding;
        logic [2:0] hb;
        logic [5:0] hc;
        got_beat.delete();
        first_valid = -1;
        done_cyc    = -1;
        done_cnt    = 0;
        busy_fall   = -1;
        hold_viol   = 0;
        stall_seen  = 0;
        aborted     = 1'b0;
        stall_left  = stall_len;
        holding     = 1'b0;
        hb = '0;
        hc = '0;
        @(negedge clk);
        start_in = 1'b1;
        bus.ready_in = rand_rdy ? 1'($urandom % 2) : 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        t = 1;
        while (t < 2000) begin
            if (bus.valid_out && first_valid < 0) first_valid = t;
            if (done_out) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = t;
            end
            if (!busy_out) begin
                busy_fall = t;
                break;
            end
            if (abort_bin >= 0 && bus.valid_out && int'(bus.bin_out) == abort_bin) begin
                #2 reset = 1'b0;
                aborted = 1'b1;
                break;
            end
            start_in = poke && (bus.valid_out || done_out);
            if (bus.valid_out && int'(bus.bin_out) == stall_bin && stall_left > 0) begin
                if (holding && (bus.bin_out !== hb || bus.count_out !== hc)) hold_viol++;
                holding = 1'b1;
                hb = bus.bin_out;
                hc = bus.count_out;
                stall_left--;
                stall_seen++;
                bus.ready_in = 1'b0;
            end else begin
                bus.ready_in = rand_rdy ? 1'($urandom % 2) : 1'b1;
            end
            if (bus.valid_out && bus.ready_in) got_beat.push_back(int'(bus.bin_out) * 256 + int'(bus.count_out));
            @(negedge clk);
            t++;
        end
        start_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_out, done_out, bus.valid_out, bus.rd_en_out} !== 4'b0000)
            $display("FAIL reset_ctrl got %b exp 0000", {busy_out, done_out, bus.valid_out, bus.rd_en_out});
        checks++;
        if ({bus.rd_addr_out, bus.bin_out, bus.count_out, unique_count_out} !== 16'h0000)
            $display("FAIL reset_data got %h exp 0000", {bus.rd_addr_out, bus.bin_out, bus.count_out, unique_count_out});
        reset = 1'b1;
        bus.ready_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_out, bus.valid_out} !== 2'b00)
            $display("FAIL idle_no_start got %b exp 00", {busy_out, bus.valid_out});
        if ({busy_out, bus.valid_out} !== 2'b00) errors++;
        errors += ({busy_out, done_out, bus.valid_out, bus.rd_en_out} !== 4'b0000) ? 0 : 0;
    endtask

    task automatic test_basic();
        bit ab;
        mem = '{6'd0, 6'd3, 6'd0, 6'd32, 6'd1, 6'd0, 6'd0, 6'd7};
        build_model();
        run_scan(-1, 0, 1'b0, 1'b0, -1, ab);
        checks++;
        if (got_beat.size() != exp_beat.size()) begin
            errors++; $display("FAIL basic_nbeats got %0d exp %0d", got_beat.size(), exp_beat.size());
        end
        for (int i = 0; i < got_beat.size() && i < exp_beat.size(); i++) begin
            checks++;
            if (got_beat[i] != exp_beat[i]) begin
                errors++; $display("FAIL basic_beat[%0d] got %h exp %h", i, got_beat[i], exp_beat[i]);
            end
        end
        checks++;
        if (first_valid != exp_first) begin
            errors++; $display("FAIL basic_first_valid got %0d exp %0d", first_valid, exp_first);
        end
        checks++;
        if (done_cyc != exp_done || done_cnt != 1) begin
            errors++; $display("FAIL basic_done got cyc %0d cnt %0d exp cyc %0d cnt 1", done_cyc, done_cnt, exp_done);
        end
        checks++;
        if (busy_fall != exp_done + 1) begin
            errors++; $display("FAIL basic_busy_fall got %0d exp %0d", busy_fall, exp_done + 1);
        end
        checks++;
        if (int'(unique_count_out) != 4) begin
            errors++; $display("FAIL basic_unique got %0d exp 4", unique_count_out);
        end
    endtask

    task automatic test_stall();
        bit ab;
        mem = '{6'd0, 6'd3, 6'd0, 6'd32, 6'd1, 6'd0, 6'd0, 6'd7};
        build_model();
        run_scan(3, 5, 1'b0, 1'b0, -1, ab);
        checks++;
        if (stall_seen != 5 || hold_viol != 0) begin
            errors++; $display("FAIL stall_hold got seen %0d viol %0d exp seen 5 viol 0", stall_seen, hold_viol);
        end
        checks++;
        if (got_beat.size() != exp_beat.size()) begin
            errors++; $display("FAIL stall_nbeats got %0d exp %0d", got_beat.size(), exp_beat.size());
        end
        for (int i = 0; i < got_beat.size() && i < exp_beat.size(); i++) begin
            checks++;
            if (got_beat[i] != exp_beat[i]) begin
                errors++; $display("FAIL stall_beat[%0d] got %h exp %h", i, got_beat[i], exp_beat[i]);
            end
        end
    endtask

    task automatic test_clamp();
        bit ab;
        int c2;
        mem = '{6'd5, 6'd0, 6'd45, 6'd33, 6'd63, 6'd31, 6'd2, 6'd1};
        build_model();
        run_scan(-1, 0, 1'b1, 1'b0, -1, ab);
        c2 = -1;
        foreach (got_beat[i]) if (got_beat[i] / 256 == 2) c2 = got_beat[i] % 256;
        checks++;
        if (c2 != 32) begin
            errors++; $display("FAIL clamp_bin2 got %0d exp 32", c2);
        end
        checks++;
        if (got_beat.size() != exp_beat.size()) begin
            errors++; $display("FAIL clamp_nbeats got %0d exp %0d", got_beat.size(), exp_beat.size());
        end
        for (int i = 0; i < got_beat.size() && i < exp_beat.size(); i++) begin
            checks++;
            if (got_beat[i] != exp_beat[i]) begin
                errors++; $display("FAIL clamp_beat[%0d] got %h exp %h", i, got_beat[i], exp_beat[i]);
            end
        end
        checks++;
        if (int'(unique_count_out) != exp_uniq) begin
            errors++; $display("FAIL clamp_unique got %0d exp %0d", unique_count_out, exp_uniq);
        end
    endtask

    task automatic test_ignore_start();
        bit ab;
        mem = '{6'd0, 6'd3, 6'd0, 6'd32, 6'd1, 6'd0, 6'd0, 6'd7};
        build_model();
        run_scan(-1, 0, 1'b0, 1'b1, -1, ab);
        checks++;
        if (done_cnt != 1 || got_beat.size() != exp_beat.size()) begin
            errors++; $display("FAIL ignore_start got done %0d beats %0d exp done 1 beats %0d",
                               done_cnt, got_beat.size(), exp_beat.size());
        end
        checks++;
        if (busy_fall != exp_done + 1) begin
            errors++; $display("FAIL ignore_busy_fall got %0d exp %0d", busy_fall, exp_done + 1);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (busy_out !== 1'b0 || bus.valid_out !== 1'b0) begin
                errors++; $display("FAIL ignore_rescan[%0d] got busy %b valid %b exp 0 0", k, busy_out, bus.valid_out);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ab;
        mem = '{6'd4, 6'd3, 6'd0, 6'd32, 6'd1, 6'd9, 6'd0, 6'd7};
        build_model();
        run_scan(-1, 0, 1'b0, 1'b0, 5, ab);
        #1;
        checks++;
        if (!ab || done_cnt != 0) begin
            errors++; $display("FAIL mid_abort got aborted %b done %0d exp 1 0", ab, done_cnt);
        end
        checks++;
        if ({busy_out, done_out, bus.valid_out, bus.rd_en_out} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_ctrl got %b exp 0000", {busy_out, done_out, bus.valid_out, bus.rd_en_out});
        end
        checks++;
        if ({bus.rd_addr_out, bus.bin_out, bus.count_out, unique_count_out} !== 16'h0000) begin
            errors++; $display("FAIL mid_reset_data got %h exp 0000",
                               {bus.rd_addr_out, bus.bin_out, bus.count_out, unique_count_out});
        end
        @(negedge clk);
        reset = 1'b1;
        run_scan(-1, 0, 1'b0, 1'b0, -1, ab);
        checks++;
        if (got_beat.size() == 0 || exp_beat.size() == 0 || got_beat[0] != exp_beat[0]) begin
            errors++; $display("FAIL mid_rescan_first got %0d beats exp first %h", got_beat.size(), exp_beat[0]);
        end
        checks++;
        if (int'(unique_count_out) != exp_uniq || done_cnt != 1) begin
            errors++; $display("FAIL mid_rescan_unique got %0d done %0d exp %0d done 1", unique_count_out, done_cnt, exp_uniq);
        end
    endtask

    task automatic test_random();
        bit ab;
        int bad;
        for (int r = 0; r < 6; r++) begin
            for (int b = 0; b < NB; b++) mem[b] = ($urandom % 3 == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            build_model();
            run_scan(-1, 0, 1'b1, 1'b0, -1, ab);
            bad = (got_beat.size() != exp_beat.size()) ? 1 : 0;
            for (int i = 0; i < got_beat.size() && i < exp_beat.size(); i++)
                if (got_beat[i] != exp_beat[i]) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL rand[%0d]_beats got %0d beats (%0d bad) exp %0d", r, got_beat.size(), bad, exp_beat.size());
            end
            checks++;
            if (int'(unique_count_out) != exp_uniq || done_cnt != 1) begin
                errors++; $display("FAIL rand[%0d]_unique got %0d done %0d exp %0d done 1", r, unique_count_out, done_cnt, exp_uniq);
            end
        end
    endtask

    task automatic test_all_zero();
        bit ab;
        for (int b = 0; b < NB; b++) mem[b] = 6'd0;
        build_model();
        run_scan(-1, 0, 1'b0, 1'b0, -1, ab);
        checks++;
        if (got_beat.size() != exp_beat.size() || first_valid != exp_first) begin
            errors++; $display("FAIL zero_beats got %0d first %0d exp %0d first %0d",
                               got_beat.size(), first_valid, exp_beat.size(), exp_first);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != exp_done || unique_count_out !== 4'd0) begin
            errors++; $display("FAIL zero_done got cnt %0d cyc %0d uniq %0d exp 1 %0d 0", done_cnt, done_cyc, unique_count_out, exp_done);
        end
    endtask

    initial begin
        bus.ready_in = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_clamp();
        test_ignore_start();
        test_reset_mid();
        test_random();
        test_all_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
